pc_gen: RTL and testbench

Parametrised program-counter generator and successor to the basic PC register/incrementer. It holds the fetch PC and selects the next PC from four sources: sequential, branch/JAL offset, JALR absolute target, or trap vector. It adds stall, a fetch valid/ready handshake, signed offsets, alignment checking and a halt state. It sits at the front of the fetch stage, driving instruction memory and the decode-stage PC pipeline register.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_if.sv | 12 +
 rtl/pc_target_calc.sv | 50 +++++
 rtl/pc_gen.sv | 101 ++++++++++
 tb/tb_pc_gen.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter generator
package pc_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JALR = 2'd2,
    SEL_TRAP = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_if.sv
// rtl/pc_if.sv - fetch request handshake between the PC generator and instruction memory
interface pc_if #(
  parameter int WIDTH = 32
);
  logic             fetch_valid;
  logic             fetch_ready;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus4;

  modport master (output fetch_valid, output pc_out, output pc_plus4, input fetch_ready);
  modport slave  (input fetch_valid, input pc_out, input pc_plus4, output fetch_ready);
endinterface

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational next-PC source select, offset arithmetic and alignment check
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               IMM_W       = 13,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic             pcsrc_i,
  input  logic [IMM_W-1:0] imm_op_i,
  input  logic             jalr_en_i,
  input  logic [WIDTH-1:0] jalr_target_i,
  input  logic             trap_en_i,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic [WIDTH-1:0] target_o,
  output logic             misaligned_o
);

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jalr_aligned;
  pc_sel_e          sel;

  // Offsets are halfword granular, so bit 0 of both redirect sources is dropped.
  assign imm_ext      = {{(WIDTH-IMM_W){imm_op_i[IMM_W-1]}}, imm_op_i} & ~WIDTH'(1);
  assign br_target    = pc_i + imm_ext;
  assign jalr_aligned = jalr_target_i & ~WIDTH'(1);
  assign pc_plus4_o   = pc_i + WIDTH'(INSTR_BYTES);

  always_comb begin
    sel = SEL_SEQ;
    if (trap_en_i)      sel = SEL_TRAP;
    else if (jalr_en_i) sel = SEL_JALR;
    else if (pcsrc_i)   sel = SEL_BR;
  end

  always_comb begin
    target_o = pc_plus4_o;
    case (sel)
      SEL_TRAP: target_o = TRAP_VECTOR;
      SEL_JALR: target_o = jalr_aligned;
      SEL_BR:   target_o = br_target;
      default:  target_o = pc_plus4_o;
    endcase
  end

  assign misaligned_o = target_o[1] && (sel != SEL_TRAP);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with boot/run/halt control, stall handshake and sticky misalignment capture
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               IMM_W        = 13,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             pcsrc,
  input  logic [IMM_W-1:0] imm_op,
  input  logic             jalr_en,
  input  logic [WIDTH-1:0] jalr_target,
  input  logic             trap_en,
  pc_if.master             fetch,
  output logic             misaligned,
  output logic [WIDTH-1:0] bad_addr,
  output logic             halted
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] bad_q, bad_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_plus4;
  logic             target_mis;
  logic             fetch_valid;
  logic             adv;

  pc_target_calc #(
    .WIDTH       (WIDTH),
    .IMM_W       (IMM_W),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_calc (
    .pc_i          (pc_q),
    .pcsrc_i       (pcsrc),
    .imm_op_i      (imm_op),
    .jalr_en_i     (jalr_en),
    .jalr_target_i (jalr_target),
    .trap_en_i     (trap_en),
    .pc_plus4_o    (pc_plus4),
    .target_o      (target),
    .misaligned_o  (target_mis)
  );

  assign fetch_valid = (state_q == RUN);
  assign adv         = fetch_valid && fetch.fetch_ready && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    bad_d   = bad_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HALT: begin
        // A trap overrides stall and the handshake; it is the only way out of HALT.
        if (trap_en) begin
          pc_d    = target;
          state_d = RUN;
          mis_d   = 1'b0;
        end else if (adv) begin
          if (target_mis) begin
            mis_d   = 1'b1;
            bad_d   = target;
            state_d = HALT;
          end else begin
            pc_d = target;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
    end
  end

  assign fetch.fetch_valid = fetch_valid;
  assign fetch.pc_out      = pc_q;
  assign fetch.pc_plus4    = pc_plus4;
  assign misaligned        = mis_q;
  assign bad_addr          = bad_q;
  assign halted            = (state_q == HALT);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic [12:0] imm_op = '0;
  logic        jalr_en = 1'b0;
  logic [31:0] jalr_target = '0;
  logic        trap_en = 1'b0;
  logic        misaligned;
  logic [31:0] bad_addr;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_if #(.WIDTH(32)) fif ();

  pc_gen #(
    .WIDTH        (32),
    .IMM_W        (13),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .imm_op      (imm_op),
    .jalr_en     (jalr_en),
    .jalr_target (jalr_target),
    .trap_en     (trap_en),
    .fetch       (fif),
    .misaligned  (misaligned),
    .bad_addr    (bad_addr),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    jalr_en     = 1'b1;
    jalr_target = addr;
    tick();
    jalr_en     = 1'b0;
  endtask

  task automatic test_reset();
    fif.fetch_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (fif.pc_out !== 32'h0 || fif.fetch_valid !== 1'b0 || misaligned !== 1'b0 || bad_addr !== 32'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h fv=%b mis=%b bad=%h halt=%b, want pc=0 fv=0 mis=0 bad=0 halt=0",
               fif.pc_out, fif.fetch_valid, misaligned, bad_addr, halted);
    end
    checks++;
    if (fif.pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL reset_pc_plus4: got %h want 00000004", fif.pc_plus4);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    rst_n = 1'b1;
    checks++;
    if (fif.fetch_valid !== 1'b0 || fif.pc_out !== 32'h0) begin
      errors++;
      $display("FAIL boot_cycle: fv=%b pc=%h want fv=0 pc=0", fif.fetch_valid, fif.pc_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (fif.pc_out !== exp_pc[i] || fif.fetch_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_%0d: pc=%h fv=%b want pc=%h fv=1", i, fif.pc_out, fif.fetch_valid, exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    jump_to(32'h40);
    checks++;
    if (fif.pc_out !== 32'h40) begin
      errors++;
      $display("FAIL jalr_to_40: got %h want 00000040", fif.pc_out);
    end
    pcsrc  = 1'b1;
    imm_op = 13'h1FF8;
    tick();
    checks++;
    if (fif.pc_out !== 32'h38) begin
      errors++;
      $display("FAIL branch_neg8: got %h want 00000038", fif.pc_out);
    end
    // 0x38 + 0xFFE = 0x1036 has bit1 set, so the branch faults instead of committing
    imm_op = 13'h0FFF;
    tick();
    pcsrc = 1'b0;
    checks++;
    if (fif.pc_out !== 32'h38 || misaligned !== 1'b1 || bad_addr !== 32'h1036 || halted !== 1'b1) begin
      errors++;
      $display("FAIL branch_bit0_forced: pc=%h mis=%b bad=%h halt=%b want pc=38 mis=1 bad=1036 halt=1",
               fif.pc_out, misaligned, bad_addr, halted);
    end
    trap_en = 1'b1;
    tick();
    trap_en = 1'b0;
    checks++;
    if (fif.pc_out !== 32'h100 || misaligned !== 1'b0 || bad_addr !== 32'h1036 || halted !== 1'b0) begin
      errors++;
      $display("FAIL branch_trap_recover: pc=%h mis=%b bad=%h halt=%b want pc=100 mis=0 bad=1036 halt=0",
               fif.pc_out, misaligned, bad_addr, halted);
    end
  endtask

  task automatic test_stall();
    jump_to(32'h10);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        stall = 1'b0;
        fif.fetch_ready = 1'b0;
      end
      tick();
      checks++;
      if (fif.pc_out !== 32'h10) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h want 00000010", i, fif.pc_out);
      end
    end
    fif.fetch_ready = 1'b1;
    tick();
    checks++;
    if (fif.pc_out !== 32'h14) begin
      errors++;
      $display("FAIL stall_release: got %h want 00000014", fif.pc_out);
    end
  endtask

  task automatic test_jalr_misalign();
    jump_to(32'h20);
    jalr_en     = 1'b1;
    pcsrc       = 1'b1;
    imm_op      = 13'h0010;
    jalr_target = 32'h203;
    tick();
    jalr_en = 1'b0;
    pcsrc   = 1'b0;
    checks++;
    if (fif.pc_out !== 32'h20 || halted !== 1'b1 || misaligned !== 1'b1 || bad_addr !== 32'h202 || fif.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL jalr_misalign: pc=%h halt=%b mis=%b bad=%h fv=%b want pc=20 halt=1 mis=1 bad=202 fv=0",
               fif.pc_out, halted, misaligned, bad_addr, fif.fetch_valid);
    end
    tick();
    checks++;
    if (fif.pc_out !== 32'h20 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_frozen: pc=%h halt=%b want pc=20 halt=1", fif.pc_out, halted);
    end
    trap_en = 1'b1;
    tick();
    trap_en = 1'b0;
    checks++;
    if (fif.pc_out !== 32'h100 || halted !== 1'b0 || misaligned !== 1'b0 || fif.fetch_valid !== 1'b1 || bad_addr !== 32'h202) begin
      errors++;
      $display("FAIL halt_trap_exit: pc=%h halt=%b mis=%b fv=%b bad=%h want pc=100 halt=0 mis=0 fv=1 bad=202",
               fif.pc_out, halted, misaligned, fif.fetch_valid, bad_addr);
    end
  endtask

  task automatic test_wrap_trap();
    jump_to(32'hFFFF_FFFC);
    checks++;
    if (fif.pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc_plus4: got %h want 00000000", fif.pc_plus4);
    end
    tick();
    checks++;
    if (fif.pc_out !== 32'h0) begin
      errors++;
      $display("FAIL wrap_advance: got %h want 00000000", fif.pc_out);
    end
    stall           = 1'b1;
    fif.fetch_ready = 1'b0;
    trap_en         = 1'b1;
    tick();
    trap_en         = 1'b0;
    stall           = 1'b0;
    fif.fetch_ready = 1'b1;
    checks++;
    if (fif.pc_out !== 32'h100) begin
      errors++;
      $display("FAIL trap_under_stall: got %h want 00000100", fif.pc_out);
    end
  endtask

  task automatic test_async_reset();
    pcsrc  = 1'b1;
    imm_op = 13'h0008;
    tick();
    checks++;
    if (fif.pc_out !== 32'h108) begin
      errors++;
      $display("FAIL pre_reset_branch: got %h want 00000108", fif.pc_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fif.pc_out !== 32'h0 || fif.fetch_valid !== 1'b0 || bad_addr !== 32'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h fv=%b bad=%h halt=%b want pc=0 fv=0 bad=0 halt=0",
               fif.pc_out, fif.fetch_valid, bad_addr, halted);
    end
    tick();
    pcsrc   = 1'b0;
    trap_en = 1'b1;
    rst_n   = 1'b1;
    checks++;
    if (fif.pc_out !== 32'h0 || fif.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_boot: pc=%h fv=%b want pc=0 fv=0", fif.pc_out, fif.fetch_valid);
    end
    tick();
    trap_en = 1'b0;
    checks++;
    if (fif.pc_out !== 32'h0 || fif.fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL boot_ignores_trap: pc=%h fv=%b want pc=0 fv=1", fif.pc_out, fif.fetch_valid);
    end
    tick();
    checks++;
    if (fif.pc_out !== 32'h4) begin
      errors++;
      $display("FAIL post_reset_seq: got %h want 00000004", fif.pc_out);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_jalr_misalign();
    test_wrap_trap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
